// File: rtl/prco_lsu_pkg.sv
// rtl/prco_lsu_pkg.sv - opcodes, state encoding and defaults for the load/store stage
package prco_lsu_pkg;

    localparam logic [4:0] PRCO_OP_LW = 5'h0A;
    localparam logic [4:0] PRCO_OP_SW = 5'h0B;

    localparam int PRCO_LSU_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_t;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == PRCO_OP_LW) || (op == PRCO_OP_SW);
    endfunction

endpackage

// File: rtl/prco_lsu.sv
// rtl/prco_lsu.sv - load/store stage: one req/ack data-RAM transaction per captured ALU result
module prco_lsu
    import prco_lsu_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int REGSEL_W    = 3,
    parameter int TIMEOUT_CYC = PRCO_LSU_TIMEOUT_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ce_ram,
    input  logic [4:0]          i_op,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_st_data,
    input  logic [REGSEL_W-1:0] i_dst_reg,
    output logic                q_ram_req,
    output logic                q_ram_we,
    output logic [ADDR_W-1:0]   q_ram_addr,
    output logic [DATA_W-1:0]   q_ram_wdata,
    input  logic                i_ram_ack,
    input  logic [DATA_W-1:0]   i_ram_rdata,
    output logic                q_ce_reg,
    output logic [REGSEL_W-1:0] q_reg_wsel,
    output logic [DATA_W-1:0]   q_reg_wdata,
    output logic                q_done,
    output logic                q_fault,
    output logic                q_busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic                is_lw;
    logic [REGSEL_W-1:0] dst_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= LSU_IDLE;
            cnt         <= '0;
            is_lw       <= 1'b0;
            dst_reg     <= '0;
            q_ram_req   <= 1'b0;
            q_ram_we    <= 1'b0;
            q_ram_addr  <= '0;
            q_ram_wdata <= '0;
            q_ce_reg    <= 1'b0;
            q_reg_wsel  <= '0;
            q_reg_wdata <= '0;
            q_done      <= 1'b0;
            q_fault     <= 1'b0;
            q_busy      <= 1'b0;
        end else begin
            // Result strobes are single-cycle; they are only raised on entry to RESP.
            q_done   <= 1'b0;
            q_ce_reg <= 1'b0;
            q_fault  <= 1'b0;

            unique case (state)
                LSU_IDLE: begin
                    if (i_ce_ram) begin
                        is_lw   <= (i_op == PRCO_OP_LW);
                        dst_reg <= i_dst_reg;
                        q_busy  <= 1'b1;
                        if (is_mem_op(i_op)) begin
                            state       <= LSU_ACCESS;
                            cnt         <= '0;
                            q_ram_req   <= 1'b1;
                            q_ram_we    <= (i_op == PRCO_OP_SW);
                            q_ram_addr  <= i_addr;
                            q_ram_wdata <= i_st_data;
                        end else begin
                            state  <= LSU_RESP;
                            q_done <= 1'b1;
                        end
                    end
                end

                LSU_ACCESS: begin
                    // An ack arriving on the final allowed cycle still counts as success.
                    if (i_ram_ack) begin
                        state     <= LSU_RESP;
                        q_ram_req <= 1'b0;
                        q_done    <= 1'b1;
                        if (is_lw) begin
                            q_ce_reg    <= 1'b1;
                            q_reg_wsel  <= dst_reg;
                            q_reg_wdata <= i_ram_rdata;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state     <= LSU_RESP;
                        q_ram_req <= 1'b0;
                        q_done    <= 1'b1;
                        q_fault   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                LSU_RESP: begin
                    state  <= LSU_IDLE;
                    q_busy <= 1'b0;
                end

                default: begin
                    state     <= LSU_IDLE;
                    q_ram_req <= 1'b0;
                    q_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prco_lsu.sv
// tb/tb_prco_lsu.sv - self-checking bench for prco_lsu with a completion scoreboard
module tb_prco_lsu;
    import prco_lsu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_ce_ram;
    logic [4:0]  i_op;
    logic [15:0] i_addr;
    logic [15:0] i_st_data;
    logic [2:0]  i_dst_reg;
    logic        q_ram_req;
    logic        q_ram_we;
    logic [15:0] q_ram_addr;
    logic [15:0] q_ram_wdata;
    logic        i_ram_ack;
    logic [15:0] i_ram_rdata;
    logic        q_ce_reg;
    logic [2:0]  q_reg_wsel;
    logic [15:0] q_reg_wdata;
    logic        q_done;
    logic        q_fault;
    logic        q_busy;

    prco_lsu #(.DATA_W(16), .ADDR_W(16), .REGSEL_W(3), .TIMEOUT_CYC(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce_ram(i_ce_ram), .i_op(i_op),
        .i_addr(i_addr), .i_st_data(i_st_data), .i_dst_reg(i_dst_reg),
        .q_ram_req(q_ram_req), .q_ram_we(q_ram_we), .q_ram_addr(q_ram_addr),
        .q_ram_wdata(q_ram_wdata), .i_ram_ack(i_ram_ack), .i_ram_rdata(i_ram_rdata),
        .q_ce_reg(q_ce_reg), .q_reg_wsel(q_reg_wsel), .q_reg_wdata(q_reg_wdata),
        .q_done(q_done), .q_fault(q_fault), .q_busy(q_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        ce_reg;
        logic [2:0]  wsel;
        logic [15:0] wdata;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    // Scoreboard consumer: every completion pulse is matched against the oldest expectation.
    always @(negedge i_clk) begin
        if (i_rst_n && q_done) begin
            n_done++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: q_done=1 with empty scoreboard");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (q_ce_reg !== e.ce_reg || q_fault !== e.fault ||
                    (e.ce_reg && (q_reg_wsel !== e.wsel || q_reg_wdata !== e.wdata))) begin
                    n_fail++;
                    $display("FAIL sb_result: ce_reg=%b fault=%b wsel=%0d wdata=%h, want ce_reg=%b fault=%b wsel=%0d wdata=%h",
                             q_ce_reg, q_fault, q_reg_wsel, q_reg_wdata, e.ce_reg, e.fault, e.wsel, e.wdata);
                end
            end
        end else if (i_rst_n && (q_ce_reg || q_fault)) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_without_done: ce_reg=%b fault=%b, want 0 0", q_ce_reg, q_fault);
        end
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [15:0] addr, input logic [15:0] data,
                         input logic [2:0] dst);
        i_ce_ram  = 1'b1;
        i_op      = op;
        i_addr    = addr;
        i_st_data = data;
        i_dst_reg = dst;
        tick();
        i_ce_ram  = 1'b0;
        i_op      = 5'h1F;
        i_addr    = 16'hDEAD;
        i_st_data = 16'h5A5A;
        i_dst_reg = 3'd0;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        i_ce_ram = 1'b0; i_op = 5'h00; i_addr = 16'h0; i_st_data = 16'h0; i_dst_reg = 3'd0;
        i_ram_ack = 1'b0; i_ram_rdata = 16'h0;
        repeat (3) tick();
        n_checks++;
        if ({q_ram_req, q_ram_we, q_ce_reg, q_done, q_fault, q_busy} !== 6'b0 ||
            q_ram_addr !== 16'h0 || q_ram_wdata !== 16'h0 || q_reg_wsel !== 3'd0 || q_reg_wdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h ce=%b wsel=%0d rdata=%h done=%b fault=%b busy=%b, want all 0",
                     q_ram_req, q_ram_we, q_ram_addr, q_ram_wdata, q_ce_reg, q_reg_wsel, q_reg_wdata, q_done, q_fault, q_busy);
        end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lw_fast;
        sb.push_back('{1'b1, 3'd3, 16'hBEEF, 1'b0});
        issue(PRCO_OP_LW, 16'h0040, 16'h1111, 3'd3);
        n_checks++;
        if (q_ram_req !== 1'b1 || q_ram_we !== 1'b0 || q_ram_addr !== 16'h0040 || q_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_req: req=%b we=%b addr=%h busy=%b, want 1 0 0040 1", q_ram_req, q_ram_we, q_ram_addr, q_busy);
        end
        i_ram_ack = 1'b1; i_ram_rdata = 16'hBEEF;
        tick();
        i_ram_ack = 1'b0; i_ram_rdata = 16'h0;
        n_checks++;
        if (q_ce_reg !== 1'b1 || q_done !== 1'b1 || q_ram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_latency: ce_reg=%b done=%b req=%b, want 1 1 0", q_ce_reg, q_done, q_ram_req);
        end
        tick();
        n_checks++;
        if (q_ce_reg !== 1'b0 || q_done !== 1'b0 || q_busy !== 1'b0 || q_reg_wdata !== 16'hBEEF || q_reg_wsel !== 3'd3) begin
            n_fail++;
            $display("FAIL lw_after: ce_reg=%b done=%b busy=%b wsel=%0d wdata=%h, want 0 0 0 3 beef",
                     q_ce_reg, q_done, q_busy, q_reg_wsel, q_reg_wdata);
        end
    endtask

    task automatic test_sw_slow;
        int bad = 0;
        sb.push_back('{1'b0, 3'd0, 16'h0, 1'b0});
        issue(PRCO_OP_SW, 16'h0012, 16'h1234, 3'd6);
        for (int i = 0; i < 3; i++) begin
            if (q_ram_req !== 1'b1 || q_ram_we !== 1'b1 || q_ram_addr !== 16'h0012 || q_ram_wdata !== 16'h1234)
                bad++;
            if (i == 2) i_ram_ack = 1'b1;
            tick();
        end
        i_ram_ack = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sw_hold: %0d cycles with unstable req/we/addr/wdata, want 0", bad);
        end
        n_checks++;
        if (q_done !== 1'b1 || q_ce_reg !== 1'b0 || q_ram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_done: done=%b ce_reg=%b req=%b, want 1 0 0", q_done, q_ce_reg, q_ram_req);
        end
        tick();
    endtask

    task automatic test_lw_timeout;
        int bad = 0;
        sb.push_back('{1'b0, 3'd0, 16'h0, 1'b1});
        issue(PRCO_OP_LW, 16'h0077, 16'h0, 3'd2);
        for (int i = 0; i < 16; i++) begin
            if (q_ram_req !== 1'b1 || q_done !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL to_hold: %0d of 16 ACCESS cycles without req, want 0", bad);
        end
        n_checks++;
        if (q_ram_req !== 1'b0 || q_done !== 1'b1 || q_fault !== 1'b1 || q_ce_reg !== 1'b0) begin
            n_fail++;
            $display("FAIL to_abort: req=%b done=%b fault=%b ce_reg=%b, want 0 1 1 0", q_ram_req, q_done, q_fault, q_ce_reg);
        end
        tick();
        i_ram_ack = 1'b1;
        tick();
        i_ram_ack = 1'b0;
        n_checks++;
        if (q_busy !== 1'b0 || q_done !== 1'b0 || q_ram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ack: busy=%b done=%b req=%b, want 0 0 0", q_busy, q_done, q_ram_req);
        end
    endtask

    task automatic test_sw_ack_last;
        int bad = 0;
        sb.push_back('{1'b0, 3'd0, 16'h0, 1'b0});
        issue(PRCO_OP_SW, 16'h0500, 16'hA5A5, 3'd1);
        for (int i = 0; i < 15; i++) begin
            if (q_ram_req !== 1'b1 || q_ram_we !== 1'b1 || q_ram_wdata !== 16'hA5A5) bad++;
            tick();
        end
        i_ram_ack = 1'b1;
        tick();
        i_ram_ack = 1'b0;
        n_checks++;
        if (bad != 0 || q_done !== 1'b1 || q_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_last: bad=%0d done=%b fault=%b, want 0 1 0", bad, q_done, q_fault);
        end
        tick();
    endtask

    task automatic test_ce_while_busy;
        int done0;
        done0 = n_done;
        sb.push_back('{1'b1, 3'd5, 16'hCAFE, 1'b0});
        issue(PRCO_OP_LW, 16'h0100, 16'h0, 3'd5);
        tick();
        i_ce_ram = 1'b1; i_op = PRCO_OP_SW; i_addr = 16'h00FF; i_st_data = 16'h9999; i_dst_reg = 3'd7;
        tick();
        i_ce_ram = 1'b0;
        n_checks++;
        if (q_ram_addr !== 16'h0100 || q_ram_we !== 1'b0 || q_ram_req !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_ignore: addr=%h we=%b req=%b, want 0100 0 1", q_ram_addr, q_ram_we, q_ram_req);
        end
        i_ram_ack = 1'b1; i_ram_rdata = 16'hCAFE;
        tick();
        i_ram_ack = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (n_done - done0 != 1 || q_reg_wsel !== 3'd5) begin
            n_fail++;
            $display("FAIL busy_done_count: dones=%0d wsel=%0d, want 1 5", n_done - done0, q_reg_wsel);
        end
    endtask

    task automatic test_async_reset;
        issue(PRCO_OP_LW, 16'h0033, 16'h0, 3'd4);
        tick();
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (q_ram_req !== 1'b0 || q_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: req=%b busy=%b, want 0 0", q_ram_req, q_busy);
        end
        sb.delete();
        i_rst_n = 1'b1;
        tick();
        sb.push_back('{1'b1, 3'd7, 16'h7777, 1'b0});
        issue(PRCO_OP_LW, 16'h0200, 16'h0, 3'd7);
        i_ram_ack = 1'b1; i_ram_rdata = 16'h7777;
        tick();
        i_ram_ack = 1'b0;
        n_checks++;
        if (q_done !== 1'b1 || q_ce_reg !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_lw: done=%b ce_reg=%b, want 1 1", q_done, q_ce_reg);
        end
        tick();
    endtask

    task automatic test_nop;
        sb.push_back('{1'b0, 3'd0, 16'h0, 1'b0});
        issue(5'h00, 16'h0444, 16'h0, 3'd2);
        n_checks++;
        if (q_ram_req !== 1'b0 || q_done !== 1'b1 || q_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nop: req=%b done=%b busy=%b, want 0 1 1", q_ram_req, q_done, q_busy);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        sb.push_back('{1'b1, 3'd1, 16'h0A0A, 1'b0});
        sb.push_back('{1'b0, 3'd0, 16'h0, 1'b0});
        issue(PRCO_OP_LW, 16'h0300, 16'h0, 3'd1);
        i_ram_ack = 1'b1; i_ram_rdata = 16'h0A0A;
        tick();
        i_ram_ack = 1'b0;
        tick();
        issue(PRCO_OP_SW, 16'h0301, 16'h5555, 3'd0);
        n_checks++;
        if (q_ram_req !== 1'b1 || q_ram_we !== 1'b1 || q_ram_addr !== 16'h0301 || q_ram_wdata !== 16'h5555) begin
            n_fail++;
            $display("FAIL b2b_req: req=%b we=%b addr=%h wdata=%h, want 1 1 0301 5555",
                     q_ram_req, q_ram_we, q_ram_addr, q_ram_wdata);
        end
        i_ram_ack = 1'b1;
        tick();
        i_ram_ack = 1'b0;
        tick();
        n_checks++;
        if (sb.size() != 0 || q_reg_wdata !== 16'h0A0A) begin
            n_fail++;
            $display("FAIL b2b_drain: pending=%0d wdata=%h, want 0 0a0a", sb.size(), q_reg_wdata);
        end
    endtask

    initial begin
        test_reset();
        test_lw_fast();
        test_sw_slow();
        test_lw_timeout();
        test_sw_ack_last();
        test_ce_while_busy();
        test_async_reset();
        test_nop();
        test_back_to_back();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
